// File: rtl/img_frame_ctrl.sv
// Frame sequencer: accepts start_req + sel_in, then drives vsync lead-in, per-line blanking and active pixel-pair timing.
// Latency: start_ack one cycle after an accepted request; ctrl_done START_DELAY + HEIGHT*(HSYNC_DELAY+WIDTH/2) cycles after start_ack.
// Backpressure: none downstream; start_req is held by the requester until start_ack, abort cancels a running frame.
//
// Ports:
//   HCLK, HRESET          clock, synchronous active-high reset
//   start_req, sel_in     frame request and its operation select
//   abort                 cancel the running frame (ignored in IDLE)
//   start_ack             one-cycle accept pulse
//   busy, vsync, hsync    frame / lead-in / active-pair strobes
//   sel, row, col         latched select, line index, even column of the pixel pair
//   ctrl_done             one-cycle pulse after the last pixel pair
// Optional feature: define IMG_FRAME_CTRL_PENDING_EN for a one-deep request slot
// that lets a request arriving mid-frame start immediately after DONE.
module img_frame_ctrl #(
    parameter int WIDTH       = 768,
    parameter int HEIGHT      = 512,
    parameter int START_DELAY = 100,
    parameter int HSYNC_DELAY = 160,
    parameter int COL_W       = 10,
    parameter int ROW_W       = 9
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             start_req,
    input  logic [1:0]       sel_in,
    input  logic             abort,
    output logic             start_ack,
    output logic             busy,
    output logic [1:0]       sel,
    output logic             vsync,
    output logic             hsync,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             ctrl_done
);

    localparam int DMAX  = (START_DELAY > HSYNC_DELAY) ? START_DELAY : HSYNC_DELAY;
    localparam int CNT_W = (DMAX > 1) ? $clog2(DMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_HBLANK,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [ROW_W-1:0] r_row, w_row_nxt;
    logic [COL_W-1:0] r_col, w_col_nxt;
    logic [1:0]       r_sel, w_sel_nxt;
    logic             w_ack_nxt;
    logic             r_ack, r_busy, r_vsync, r_hsync, r_done;
`ifdef IMG_FRAME_CTRL_PENDING_EN
    logic             r_slot_vld, w_slot_vld_nxt;
    logic [1:0]       r_slot_sel, w_slot_sel_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_sel_nxt   = r_sel;
        w_ack_nxt   = 1'b0;
`ifdef IMG_FRAME_CTRL_PENDING_EN
        w_slot_vld_nxt = r_slot_vld;
        w_slot_sel_nxt = r_slot_sel;
`endif
        case (r_state)
            S_IDLE: begin
                if (start_req && !abort) begin
                    w_state_nxt = S_VSYNC;
                    w_ack_nxt   = 1'b1;
                    w_sel_nxt   = sel_in;
                    w_cnt_nxt   = '0;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end
            end
            S_VSYNC: begin
                if (r_cnt == CNT_W'(START_DELAY - 1)) begin
                    w_state_nxt = S_HBLANK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_HBLANK: begin
                if (r_cnt == CNT_W'(HSYNC_DELAY - 1)) begin
                    w_state_nxt = S_ACTIVE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_ACTIVE: begin
                if (r_col == COL_W'(WIDTH - 2)) begin
                    // Last pair of the line: final line holds row/col for DONE.
                    if (r_row == ROW_W'(HEIGHT - 1)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_HBLANK;
                        w_row_nxt   = r_row + ROW_W'(1);
                        w_col_nxt   = '0;
                    end
                end else begin
                    w_col_nxt = r_col + COL_W'(2);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
`ifdef IMG_FRAME_CTRL_PENDING_EN
                // Chain straight into the next frame: queued request first,
                // otherwise a request arriving on the DONE cycle itself.
                if (r_slot_vld) begin
                    w_state_nxt    = S_VSYNC;
                    w_sel_nxt      = r_slot_sel;
                    w_slot_vld_nxt = 1'b0;
                    w_cnt_nxt      = '0;
                    w_row_nxt      = '0;
                    w_col_nxt      = '0;
                end else if (start_req) begin
                    w_state_nxt = S_VSYNC;
                    w_ack_nxt   = 1'b1;
                    w_sel_nxt   = sel_in;
                    w_cnt_nxt   = '0;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                end
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase

`ifdef IMG_FRAME_CTRL_PENDING_EN
        if ((r_state == S_VSYNC || r_state == S_HBLANK || r_state == S_ACTIVE) &&
            start_req && !r_slot_vld) begin
            w_slot_vld_nxt = 1'b1;
            w_slot_sel_nxt = sel_in;
            w_ack_nxt      = 1'b1;
        end
`endif

        // Abort overrides everything except IDLE; DONE's ctrl_done is already out.
        if (abort && r_state != S_IDLE) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_row_nxt   = '0;
            w_col_nxt   = '0;
            w_ack_nxt   = 1'b0;
`ifdef IMG_FRAME_CTRL_PENDING_EN
            w_slot_vld_nxt = 1'b0;
`endif
        end
    end

    // Strobes are decoded from the next state so every output is a flop.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_sel   <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_vsync <= 1'b0;
            r_hsync <= 1'b0;
            r_done  <= 1'b0;
`ifdef IMG_FRAME_CTRL_PENDING_EN
            r_slot_vld <= 1'b0;
            r_slot_sel <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_sel   <= w_sel_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_vsync <= (w_state_nxt == S_VSYNC);
            r_hsync <= (w_state_nxt == S_ACTIVE);
            r_done  <= (w_state_nxt == S_DONE);
`ifdef IMG_FRAME_CTRL_PENDING_EN
            r_slot_vld <= w_slot_vld_nxt;
            r_slot_sel <= w_slot_sel_nxt;
`endif
        end
    end

    assign start_ack = r_ack;
    assign busy      = r_busy;
    assign sel       = r_sel;
    assign vsync     = r_vsync;
    assign hsync     = r_hsync;
    assign row       = r_row;
    assign col       = r_col;
    assign ctrl_done = r_done;

endmodule
